// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronized rising edges of `signal` over a
// free-running window of GATE_CYCLES clocks and publishes the saturated count.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 32'd50_000_000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  output logic [CNT_W-1:0] freq,
  output logic             freq_vld,
  output logic             ovf
);

  localparam int unsigned GW   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             pulse;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             close;
  logic             at_max;
  logic             sat_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign pulse   = s2 & ~s3;
  assign close   = (gate_cnt == LAST);
  assign at_max  = &edge_cnt;
  assign sat_hit = pulse & at_max;
  // Count including this cycle's pulse, held at full scale instead of wrapping.
  assign cnt_inc = (pulse && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt <= '0;
    end else if (close) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + GW'(1);
    end
  end

  // A pulse on the close edge goes to the closing window; the new one starts empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (close) begin
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      edge_cnt <= cnt_inc;
      if (sat_hit) begin
        sat <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq     <= '0;
      ovf      <= 1'b0;
      freq_vld <= 1'b0;
    end else begin
      freq_vld <= close;
      if (close) begin
        freq <= cnt_inc;
        ovf  <= sat | sat_hit;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: two instances (16-bit and 4-bit results) against
// a window-level edge-count model, driven by phase tables and hand sequences.
module tb_freq_gate_counter;

  localparam int G = 100;

  logic        clk;
  logic        rst;
  logic        sig;
  logic [15:0] freq_a;
  logic        vld_a;
  logic        ovf_a;
  logic [3:0]  freq_b;
  logic        vld_b;
  logic        ovf_b;

  freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .signal(sig), .freq(freq_a), .freq_vld(vld_a), .ovf(ovf_a)
  );
  freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .signal(sig), .freq(freq_b), .freq_vld(vld_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit do_reset;
    bit init_level;
    int kind;        // 0 periodic, 1 constant, 2 random
    int period;
    int windows;
    bit check_first;
    int first_f16;
    bit check_last;
    int exp_f16;
    int exp_o16;
    int exp_f4;
    int exp_o4;
  } vec_t;

  vec_t vecs[6];

  int n_vec;
  int n_miss;

  // Reference model: sampled input history and rising edges per window.
  int   e;
  logic samp[$];
  int   win_rises;
  int   exp_vld;
  int   exp_f16;
  int   exp_o16;
  int   exp_f4;
  int   exp_o4;

  int nstrobe;
  int first_f16;
  int last_f16;
  int last_o16;
  int last_f4;
  int last_o4;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " freq_a"}, freq_a, 0);
    chk({tag, " vld_a"}, vld_a, 0);
    chk({tag, " ovf_a"}, ovf_a, 0);
    chk({tag, " freq_b"}, freq_b, 0);
    chk({tag, " vld_b"}, vld_b, 0);
    chk({tag, " ovf_b"}, ovf_b, 0);
  endtask

  task automatic model_clear();
    e = 0;
    samp.delete();
    win_rises = 0;
    exp_vld = 0;
    exp_f16 = 0;
    exp_o16 = 0;
    exp_f4 = 0;
    exp_o4 = 0;
    nstrobe = 0;
  endtask

  // Ends just after a posedge with rst still high; the next step releases it.
  task automatic do_reset(input logic lvl);
    @(negedge clk);
    rst = 1'b1;
    sig = lvl;
    #1;
    chk_zero("reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk_zero("reset_hold");
    model_clear();
  endtask

  task automatic step(input logic v);
    logic a;
    logic b;
    logic p;
    @(negedge clk);
    rst = 1'b0;
    sig = v;
    samp.push_back(v);
    a = (e >= 2) ? samp[e-2] : 1'b0;
    b = (e >= 3) ? samp[e-3] : 1'b0;
    p = a & ~b;
    if (p) win_rises++;
    if ((e % G) == G - 1) begin
      exp_vld = 1;
      exp_f16 = (win_rises > 65535) ? 65535 : win_rises;
      exp_o16 = (win_rises > 65535) ? 1 : 0;
      exp_f4  = (win_rises > 15) ? 15 : win_rises;
      exp_o4  = (win_rises > 15) ? 1 : 0;
      win_rises = 0;
    end else begin
      exp_vld = 0;
    end
    @(posedge clk);
    #1;
    chk($sformatf("vld_a e=%0d", e), vld_a, exp_vld);
    chk($sformatf("freq_a e=%0d", e), freq_a, exp_f16);
    chk($sformatf("ovf_a e=%0d", e), ovf_a, exp_o16);
    chk($sformatf("vld_b e=%0d", e), vld_b, exp_vld);
    chk($sformatf("freq_b e=%0d", e), freq_b, exp_f4);
    chk($sformatf("ovf_b e=%0d", e), ovf_b, exp_o4);
    if (vld_a) begin
      nstrobe++;
      if (nstrobe == 1) first_f16 = int'(freq_a);
      last_f16 = int'(freq_a);
      last_o16 = int'(ovf_a);
      last_f4  = int'(freq_b);
      last_o4  = int'(ovf_b);
    end
    e++;
  endtask

  initial begin
    logic lvl;
    int   rem;
    logic v;

    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    sig = 1'b0;
    model_clear();
    first_f16 = 0;
    last_f16 = 0;
    last_o16 = 0;
    last_f4 = 0;
    last_o4 = 0;

    //          rst init kind per win cf  f1 cl  f16 o16 f4 o4
    vecs[0] = '{1, 1, 0, 10, 3, 0, 0, 1, 10, 0, 10, 0};
    vecs[1] = '{1, 1, 1,  0, 3, 1, 1, 1,  0, 0,  0, 0};
    vecs[2] = '{1, 0, 1,  0, 2, 1, 0, 1,  0, 0,  0, 0};
    vecs[3] = '{1, 1, 0,  4, 2, 0, 0, 1, 25, 0, 15, 1};
    vecs[4] = '{0, 1, 0, 20, 2, 0, 0, 1,  5, 0,  5, 0};
    vecs[5] = '{1, 0, 2,  0, 4, 0, 0, 0,  0, 0,  0, 0};

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_reset) do_reset(vecs[i].init_level);
      nstrobe = 0;
      lvl = vecs[i].init_level;
      rem = 0;
      for (int t = 0; t < vecs[i].windows * G; t++) begin
        case (vecs[i].kind)
          0: v = ((t % vecs[i].period) < (vecs[i].period / 2));
          1: v = vecs[i].init_level;
          default: begin
            if (rem == 0) begin
              lvl = ~lvl;
              rem = int'($urandom_range(1, 6));
            end
            rem--;
            v = lvl;
          end
        endcase
        step(v);
      end
      chk($sformatf("vec%0d strobes", i), nstrobe, vecs[i].windows);
      if (vecs[i].check_first) chk($sformatf("vec%0d first_f16", i), first_f16, vecs[i].first_f16);
      if (vecs[i].check_last) begin
        chk($sformatf("vec%0d f16", i), last_f16, vecs[i].exp_f16);
        chk($sformatf("vec%0d o16", i), last_o16, vecs[i].exp_o16);
        chk($sformatf("vec%0d f4", i), last_f4, vecs[i].exp_f4);
        chk($sformatf("vec%0d o4", i), last_o4, vecs[i].exp_o4);
      end
      $display("vec%0d kind=%0d period=%0d strobes=%0d last f16=%0d o16=%0d f4=%0d o4=%0d",
               i, vecs[i].kind, vecs[i].period, nstrobe, last_f16, last_o16, last_f4, last_o4);
    end

    // Edge pulse landing exactly on the close edge of window 0.
    do_reset(1'b0);
    for (int t = 0; t < 2 * G; t++) step((t >= 97) && (t < 105));
    chk("boundary strobes", nstrobe, 2);
    chk("boundary closing", first_f16, 1);
    chk("boundary next", last_f16, 0);
    $display("boundary first=%0d next=%0d", first_f16, last_f16);

    // Asynchronous reset with gate_cnt at 57 in the second window.
    do_reset(1'b0);
    for (int t = 0; t < G + 57; t++) step((t % 10) < 5);
    chk("pre_abort freq_a", freq_a, 10);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    do_reset(1'b0);
    for (int t = 0; t < G; t++) step((t % 10) < 5);
    chk("post_abort strobes", nstrobe, 1);
    $display("mid_window_reset strobes_after_release=%0d freq=%0d", nstrobe, last_f16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
